// File: rtl/pcs_eth_10g_err_pkg.sv
// Shared error-bit index constants and the default RX error remap for the 10G MAC.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pcs_eth_10g_err_pkg;

    // Input-side error bit positions, as driven by the RX frame decoder
    localparam int ERR_PHY         = 0;
    localparam int ERR_CRC         = 1;
    localparam int ERR_UNDERSIZE   = 2;
    localparam int ERR_OVERSIZE    = 3;
    localparam int ERR_PAYLOAD_LEN = 4;

    // Output-side error bit positions, as seen by the statistics/client stream
    localparam int OUT_UNDERSIZE   = 0;
    localparam int OUT_OVERSIZE    = 1;
    localparam int OUT_PAYLOAD_LEN = 2;
    localparam int OUT_CRC         = 3;
    localparam int OUT_PHY         = 6;

    localparam int              ERR_MAP_IDX_W = 4;
    localparam logic [3:0]      MAP_UNUSED    = 4'hF;

    // Output bits 4 and 5 are reserved and tied low. Evaluates to 28'h0FF1432.
    localparam logic [27:0] ERR_MAP_DEFAULT =
          (28'(ERR_UNDERSIZE)   << (OUT_UNDERSIZE   * ERR_MAP_IDX_W))
        | (28'(ERR_OVERSIZE)    << (OUT_OVERSIZE    * ERR_MAP_IDX_W))
        | (28'(ERR_PAYLOAD_LEN) << (OUT_PAYLOAD_LEN * ERR_MAP_IDX_W))
        | (28'(ERR_CRC)         << (OUT_CRC         * ERR_MAP_IDX_W))
        | (28'(MAP_UNUSED)      << (4               * ERR_MAP_IDX_W))
        | (28'(MAP_UNUSED)      << (5               * ERR_MAP_IDX_W))
        | (28'(ERR_PHY)         << (OUT_PHY         * ERR_MAP_IDX_W));

endpackage

// File: rtl/st_skid_buffer.sv
// Generic 2-entry ready/valid register stage: main output register plus one skid entry.
// Latency: 1 cycle from acceptance to out_valid when empty; 1 beat/cycle while out_ready=1.
// Backpressure: in_ready is the flopped "skid empty" state, so it drops the cycle after the skid fills.
// Ports: clk, reset_n (async active-low); in_valid/in_ready/in_data upstream;
//        out_valid/out_ready/out_data downstream (out_data held while stalled).
module st_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_full;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         main_load;

    assign in_ready  = !skid_full;
    assign accept    = in_valid && !skid_full;
    // Main register may take a new value when empty or being drained this cycle
    assign main_load = !out_valid || out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_full <= 1'b0;
            skid_data <= '0;
        end else if (main_load) begin
            // in_ready is low whenever the skid is full, so no beat can arrive in that case
            if (skid_full) begin
                out_valid <= 1'b1;
                out_data  <= skid_data;
                skid_full <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) begin
                    out_data <= in_data;
                end
            end
        end else if (accept) begin
            // Main is stalled: park the beat so it is not lost
            skid_data <= in_data;
            skid_full <= 1'b1;
        end
    end

endmodule

// File: rtl/pcs_eth_10g_mac_rx_st_error_adapter_pipe.sv
// Registered Avalon-ST error adapter: remaps IN_ERR_W error flags onto OUT_ERR_W via ERR_MAP, counts errors per output bit.
// Latency: 1 cycle acceptance to out_valid; sustains 1 beat/cycle.
// Backpressure: 2-entry skid; in_ready drops the cycle after the skid fills, nothing is dropped or duplicated.
// Ports: clk, reset_n (async active-low); in_valid/in_ready/in_data/in_error upstream;
//        out_valid/out_ready/out_data/out_error downstream; stat_clear (sync), stat_count (counter i at [i*CNT_W +: CNT_W]).
// Build option: define SONIC_RX_ERR_ADAPTER_STAT_EN to build the saturating counters;
//               otherwise stat_count is tied to 0 and stat_clear is ignored.
module pcs_eth_10g_mac_rx_st_error_adapter_pipe
    import pcs_eth_10g_err_pkg::*;
#(
    parameter int                                  DATA_W    = 40,
    parameter int                                  IN_ERR_W  = 5,
    parameter int                                  OUT_ERR_W = 7,
    parameter int                                  MAP_IDX_W = 4,
    parameter logic [OUT_ERR_W*MAP_IDX_W-1:0]      ERR_MAP   = (OUT_ERR_W*MAP_IDX_W)'(ERR_MAP_DEFAULT),
    parameter int                                  CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [IN_ERR_W-1:0]        in_error,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [OUT_ERR_W-1:0]       out_error,
    input  logic                       stat_clear,
    output logic [OUT_ERR_W*CNT_W-1:0] stat_count
);

    logic [OUT_ERR_W-1:0] mapped;

    // A field only matches an existing input index; the all-ones "unused" value and any
    // other out-of-range index match nothing and leave the output bit at 0.
    always_comb begin
        mapped = '0;
        for (int i = 0; i < OUT_ERR_W; i++) begin
            for (int j = 0; j < IN_ERR_W; j++) begin
                if (ERR_MAP[i*MAP_IDX_W +: MAP_IDX_W] == MAP_IDX_W'(j)) begin
                    mapped[i] = in_error[j];
                end
            end
        end
    end

    st_skid_buffer #(
        .W (DATA_W + OUT_ERR_W)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_data, mapped}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({out_data, out_error})
    );

`ifdef SONIC_RX_ERR_ADAPTER_STAT_EN
    logic                 xfer;
    logic [CNT_W-1:0]     cnt [OUT_ERR_W];

    assign xfer = out_valid && out_ready;

    // Clear has priority: an event coinciding with stat_clear is intentionally lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < OUT_ERR_W; i++) begin
                cnt[i] <= '0;
            end
        end else if (stat_clear) begin
            for (int i = 0; i < OUT_ERR_W; i++) begin
                cnt[i] <= '0;
            end
        end else if (xfer) begin
            for (int i = 0; i < OUT_ERR_W; i++) begin
                if (out_error[i] && (cnt[i] != {CNT_W{1'b1}})) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < OUT_ERR_W; g++) begin : g_stat
        assign stat_count[g*CNT_W +: CNT_W] = cnt[g];
    end
`else
    logic unused_stat_clear;

    assign unused_stat_clear = stat_clear;
    assign stat_count        = '0;
`endif

endmodule

// File: tb/tb_pcs_eth_10g_mac_rx_st_error_adapter_pipe.sv
// Self-checking bench for pcs_eth_10g_mac_rx_st_error_adapter_pipe.
// Two instances (default map and a custom map) share one stimulus stream; a queue/array
// reference model predicts handshakes, payloads, remapped errors and counters.
module tb_pcs_eth_10g_mac_rx_st_error_adapter_pipe;

`ifdef SONIC_RX_ERR_ADAPTER_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    localparam logic [27:0] MAP_A = 28'h0FF1432;
    // field0=F (unused), field1=0, field2=7 (out of range), field3=3, field4=2, field5=1, field6=0
    localparam logic [27:0] MAP_B = 28'h012370F;
    localparam int          CMAX  = 15;

    typedef struct packed {
        logic [39:0] d;
        logic [6:0]  e;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [39:0] in_data;
    logic [4:0]  in_error;
    logic        out_ready;
    logic        stat_clear;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [39:0] a_out_data, b_out_data;
    logic [6:0]  a_out_error, b_out_error;
    logic [27:0] a_stat, b_stat;

    beat_t qa[$];
    beat_t qb[$];
    int    ca[7];
    int    cb[7];
    int    checks = 0;
    int    errors = 0;
    logic  acc;

    always #5 clk = ~clk;

    pcs_eth_10g_mac_rx_st_error_adapter_pipe #(
        .DATA_W (40), .IN_ERR_W (5), .OUT_ERR_W (7), .MAP_IDX_W (4), .ERR_MAP (MAP_A), .CNT_W (4)
    ) dut_a (
        .clk (clk), .reset_n (reset_n),
        .in_valid (in_valid), .in_ready (a_in_ready), .in_data (in_data), .in_error (in_error),
        .out_valid (a_out_valid), .out_ready (out_ready), .out_data (a_out_data), .out_error (a_out_error),
        .stat_clear (stat_clear), .stat_count (a_stat)
    );

    pcs_eth_10g_mac_rx_st_error_adapter_pipe #(
        .DATA_W (40), .IN_ERR_W (5), .OUT_ERR_W (7), .MAP_IDX_W (4), .ERR_MAP (MAP_B), .CNT_W (4)
    ) dut_b (
        .clk (clk), .reset_n (reset_n),
        .in_valid (in_valid), .in_ready (b_in_ready), .in_data (in_data), .in_error (in_error),
        .out_valid (b_out_valid), .out_ready (out_ready), .out_data (b_out_data), .out_error (b_out_error),
        .stat_clear (stat_clear), .stat_count (b_stat)
    );

    // Reference remap straight from the rule: an in-range field selects that input bit, anything else is 0
    function automatic logic [6:0] map_err(input logic [27:0] m, input logic [4:0] e);
        logic [6:0] r;
        int         f;
        r = '0;
        for (int i = 0; i < 7; i++) begin
            f = int'(m[i*4 +: 4]);
            if (f < 5) r[i] = e[f];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        qa.delete();
        qb.delete();
        for (int i = 0; i < 7; i++) begin
            ca[i] = 0;
            cb[i] = 0;
        end
    endtask

    // Occupancy view: up to two beats held; in_ready means fewer than two held
    task automatic check_outputs();
        logic [27:0] ea;
        logic [27:0] eb;
        chk("a_in_ready",  64'(a_in_ready),  64'(qa.size() < 2));
        chk("b_in_ready",  64'(b_in_ready),  64'(qb.size() < 2));
        chk("a_out_valid", 64'(a_out_valid), 64'(qa.size() > 0));
        chk("b_out_valid", 64'(b_out_valid), 64'(qb.size() > 0));
        if (qa.size() > 0) begin
            chk("a_out_data",  64'(a_out_data),  64'(qa[0].d));
            chk("a_out_error", 64'(a_out_error), 64'(qa[0].e));
        end
        if (qb.size() > 0) begin
            chk("b_out_data",  64'(b_out_data),  64'(qb[0].d));
            chk("b_out_error", 64'(b_out_error), 64'(qb[0].e));
        end
        for (int i = 0; i < 7; i++) begin
            ea[i*4 +: 4] = STAT_EN ? 4'(ca[i]) : 4'h0;
            eb[i*4 +: 4] = STAT_EN ? 4'(cb[i]) : 4'h0;
        end
        chk("a_stat", 64'(a_stat), 64'(ea));
        chk("b_stat", 64'(b_stat), 64'(eb));
    endtask

    // Called at a falling edge: check settled outputs, drive one cycle, advance the model across the rising edge
    task automatic cyc(input logic iv, input logic [39:0] d, input logic [4:0] e,
                       input logic ordy, input logic clr, output logic accepted);
        beat_t ba;
        beat_t bb;
        check_outputs();
        in_valid   = iv;
        in_data    = d;
        in_error   = e;
        out_ready  = ordy;
        stat_clear = clr;
        accepted   = iv && (qa.size() < 2);
        if (qa.size() > 0 && ordy) begin
            ba = qa.pop_front();
            bb = qb.pop_front();
            for (int i = 0; i < 7; i++) begin
                if (ba.e[i] && ca[i] < CMAX) ca[i]++;
                if (bb.e[i] && cb[i] < CMAX) cb[i]++;
            end
        end
        if (clr) begin
            for (int i = 0; i < 7; i++) begin
                ca[i] = 0;
                cb[i] = 0;
            end
        end
        if (accepted) begin
            qa.push_back('{d: d, e: map_err(MAP_A, e)});
            qb.push_back('{d: d, e: map_err(MAP_B, e)});
        end
        @(negedge clk);
    endtask

    // Reset takes effect without a clock edge; released at the following falling edge
    task automatic do_reset(input string tag);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        chk({tag, "_a_out_valid"}, 64'(a_out_valid), 64'd0);
        chk({tag, "_a_in_ready"},  64'(a_in_ready),  64'd1);
        chk({tag, "_a_out_data"},  64'(a_out_data),  64'd0);
        chk({tag, "_a_out_error"}, 64'(a_out_error), 64'd0);
        chk({tag, "_a_stat"},      64'(a_stat),      64'd0);
        chk({tag, "_b_out_valid"}, 64'(b_out_valid), 64'd0);
        chk({tag, "_b_in_ready"},  64'(b_in_ready),  64'd1);
        chk({tag, "_b_stat"},      64'(b_stat),      64'd0);
        clear_model();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int          sent;
        logic [39:0] d3;

        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_error   = '0;
        out_ready  = 1'b0;
        stat_clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_reset("rst0");

        // 1: default map, single beats
        cyc(1'b1, 40'hA1, 5'b00001, 1'b1, 1'b0, acc);
        chk("t1_valid", 64'(a_out_valid), 64'd1);
        chk("t1_err_phy", 64'(a_out_error), 64'(7'b1000000));
        cyc(1'b1, 40'hA2, 5'b00010, 1'b1, 1'b0, acc);
        chk("t1_err_crc", 64'(a_out_error), 64'(7'b0001000));
        cyc(1'b0, 40'h0, 5'b0, 1'b1, 1'b0, acc);
        chk("t1_cnt6", 64'(a_stat[27:24]), STAT_EN ? 64'd1 : 64'd0);
        chk("t1_cnt3", 64'(a_stat[15:12]), STAT_EN ? 64'd1 : 64'd0);

        // 2: 8-beat stream with a 4-cycle stall starting at beat 3
        sent = 0;
        for (int c = 0; c < 24; c++) begin
            if (c == 4) chk("t2_in_ready_low", 64'(a_in_ready), 64'd0);
            cyc(sent < 8, 40'h BE_0000_0000 + 40'(sent), 5'(sent), !(c >= 3 && c < 7), 1'b0, acc);
            if (acc) sent++;
        end
        chk("t2_all_sent", 64'(sent), 64'd8);
        chk("t2_drained", 64'(a_out_valid), 64'd0);

        // 3: saturation of counter 0 (in_error[2]) then clear
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 40'({$urandom(), $urandom()}), 5'b00100, 1'b1, 1'b0, acc);
        end
        cyc(1'b0, 40'h0, 5'b0, 1'b1, 1'b0, acc);
        chk("t3_sat", 64'(a_stat[3:0]), STAT_EN ? 64'hF : 64'h0);
        cyc(1'b0, 40'h0, 5'b0, 1'b1, 1'b1, acc);
        chk("t3_clr", 64'(a_stat[3:0]), 64'h0);

        // 4: clear coinciding with a counted transfer
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 40'h4400 + 40'(k), 5'b01000, 1'b1, 1'b0, acc);
        end
        chk("t4_cnt1_pre", 64'(a_stat[7:4]), STAT_EN ? 64'd2 : 64'd0);
        cyc(1'b0, 40'h0, 5'b0, 1'b1, 1'b1, acc);
        chk("t4_cnt1", 64'(a_stat[7:4]), 64'd0);

        // 5: custom map with unused and out-of-range fields
        cyc(1'b1, 40'h55, 5'b11111, 1'b1, 1'b0, acc);
        chk("t5_b_err", 64'(b_out_error), 64'(7'b1111010));
        chk("t5_b_err0", 64'(b_out_error[0]), 64'd0);
        chk("t5_b_err2", 64'(b_out_error[2]), 64'd0);
        cyc(1'b0, 40'h0, 5'b0, 1'b1, 1'b0, acc);
        chk("t5_b_cnt0", 64'(b_stat[3:0]), 64'd0);
        chk("t5_b_cnt1", 64'(b_stat[7:4]), STAT_EN ? 64'd1 : 64'd0);

        // Random traffic, backpressure and occasional clears
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 3) != 0, 40'({$urandom(), $urandom()}), 5'($urandom()),
                $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, acc);
        end

        // 6: reset with the skid full
        cyc(1'b1, 40'h61, 5'b10101, 1'b0, 1'b0, acc);
        cyc(1'b1, 40'h62, 5'b01010, 1'b0, 1'b0, acc);
        chk("t6_skid_full", 64'(a_in_ready), 64'd0);
        chk("t6_pre_valid", 64'(a_out_valid), 64'd1);
        do_reset("t6_rst");
        d3 = 40'h63_0000_0063;
        cyc(1'b1, d3, 5'b00011, 1'b1, 1'b0, acc);
        chk("t6_out_valid", 64'(a_out_valid), 64'd1);
        chk("t6_out_data", 64'(a_out_data), 64'(d3));
        cyc(1'b0, 40'h0, 5'b0, 1'b1, 1'b0, acc);
        cyc(1'b0, 40'h0, 5'b0, 1'b1, 1'b0, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
